// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift_sched controller.
// Optional rotate support is enabled with SHIFT_SCHED_ROT_EN.
package shift_sched_pkg;
    localparam int DW_P = 8;
    localparam int SW_P = 3;
    localparam int AW_P = 4;

    localparam int   SH_MAX_STEP = 7;
    localparam logic LR_LEFT     = 1'b1;
    localparam logic AL_ARITH    = 1'b1;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    typedef struct packed {
        logic [DW_P-1:0] din;
        logic [AW_P-1:0] amt;
        logic            lr;
        logic            al;
`ifdef SHIFT_SCHED_ROT_EN
        logic            rot;
`endif
    } req_t;
endpackage

// File: rtl/shift_sched_rr_arb.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module shift_sched_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       gidx
);
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b10:   gidx = 1'b1;
            2'b11:   gidx = ~last_grant;
            default: gidx = 1'b0;
        endcase
        if (enable && valid != 2'b00)
            grant = 2'b01 << gidx;
    end
endmodule

// File: rtl/shift_sched.sv
// Shares one 8-bit barrel shifter between two requesters, building shifts of
// up to 15 bits from passes of at most 7. SHIFT_SCHED_ROT_EN adds rotates.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int DW = DW_P,
    parameter int SW = SW_P,
    parameter int AW = AW_P
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req0_din,
    input  logic [DW-1:0] req1_din,
    input  logic [AW-1:0] req0_amt,
    input  logic [AW-1:0] req1_amt,
    input  logic          req0_lr,
    input  logic          req1_lr,
    input  logic          req0_al,
    input  logic          req1_al,
`ifdef SHIFT_SCHED_ROT_EN
    input  logic          req0_rot,
    input  logic          req1_rot,
`endif
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_id,
    output logic [DW-1:0] sh_din,
    output logic [SW-1:0] sh_shamt,
    output logic          sh_lr,
    output logic          sh_al,
    input  logic [DW-1:0] sh_dout
);
    state_t        state, state_nx;
    logic [DW-1:0] acc;
    logic [AW-1:0] rem, rem_nx;
    logic [SW-1:0] step;
    logic          lr, al, id, last_grant;
    logic [1:0]    grant;
    logic          gidx, accept;
    req_t          sel;
`ifdef SHIFT_SCHED_ROT_EN
    logic          rot, phase;
    logic [DW-1:0] tmp;
`endif

    shift_sched_rr_arb u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .enable     (state == IDLE && !rst),
        .grant      (grant),
        .gidx       (gidx)
    );

    assign req_ready  = grant;
    assign accept     = |(req_valid & grant);
    assign resp_valid = (state == RESP);
    assign resp_data  = acc;
    assign resp_id    = id;

    assign step   = (rem > AW'(SH_MAX_STEP)) ? SW'(SH_MAX_STEP) : rem[SW-1:0];
    assign rem_nx = rem - AW'(step);

    always_comb begin
        sel = '0;
        if (gidx) begin
            sel.din = req1_din; sel.amt = req1_amt; sel.lr = req1_lr; sel.al = req1_al;
`ifdef SHIFT_SCHED_ROT_EN
            sel.rot = req1_rot;
`endif
        end else begin
            sel.din = req0_din; sel.amt = req0_amt; sel.lr = req0_lr; sel.al = req0_al;
`ifdef SHIFT_SCHED_ROT_EN
            sel.rot = req0_rot;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        sh_din   = acc;
        sh_lr    = lr;
        sh_al    = al;
        sh_shamt = '0;
        case (state)
            IDLE:  if (accept) state_nx = SHIFT;
            SHIFT: begin
                sh_shamt = step;
                if (rem_nx == '0) state_nx = RESP;
`ifdef SHIFT_SCHED_ROT_EN
                // rotate = (din shifted by k) | (din shifted the other way by 8-k)
                if (rot) begin
                    sh_al = ~AL_ARITH;
                    if (phase) begin
                        sh_shamt = '0 - rem[SW-1:0];
                        sh_lr    = ~lr;
                        state_nx = RESP;
                    end else begin
                        state_nx = (rem == '0) ? RESP : SHIFT;
                    end
                end
`endif
            end
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            lr         <= 1'b0;
            al         <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
`ifdef SHIFT_SCHED_ROT_EN
            rot        <= 1'b0;
            phase      <= 1'b0;
            tmp        <= '0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    acc        <= sel.din;
                    rem        <= sel.amt;
                    lr         <= sel.lr;
                    al         <= sel.al;
                    id         <= gidx;
                    last_grant <= gidx;
`ifdef SHIFT_SCHED_ROT_EN
                    rot   <= sel.rot;
                    phase <= 1'b0;
                    if (sel.rot) rem <= AW'(sel.amt[SW-1:0]);
`endif
                end
                SHIFT: begin
`ifdef SHIFT_SCHED_ROT_EN
                    if (rot) begin
                        if (phase)          acc <= tmp | sh_dout;
                        else if (rem == '0) acc <= sh_dout;
                        else begin
                            tmp   <= sh_dout;
                            phase <= 1'b1;
                        end
                    end else
`endif
                    begin
                        acc <= sh_dout;
                        rem <= rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: vector table, random traffic against a
// whole-shift reference, and arbitration/stall/reset sequences.
module tb_shift_sched;
    import shift_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [7:0] req0_din, req1_din;
    logic [3:0] req0_amt, req1_amt;
    logic       req0_lr, req1_lr, req0_al, req1_al;
    logic       req0_rot, req1_rot;
    logic       resp_valid, resp_ready, resp_id;
    logic [7:0] resp_data, sh_din, sh_dout;
    logic [2:0] sh_shamt;
    logic       sh_lr, sh_al;
    logic signed [7:0] sd;

    always #5 clk = ~clk;

    shift_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req0_din(req0_din), .req1_din(req1_din), .req0_amt(req0_amt), .req1_amt(req1_amt),
        .req0_lr(req0_lr), .req1_lr(req1_lr), .req0_al(req0_al), .req1_al(req1_al),
`ifdef SHIFT_SCHED_ROT_EN
        .req0_rot(req0_rot), .req1_rot(req1_rot),
`endif
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_lr(sh_lr),
        .sh_al(sh_al), .sh_dout(sh_dout)
    );

    // the external shared shifter (one pass, at most 7 bits)
    assign sd = sh_din;
    always_comb begin
        if (sh_lr == LR_LEFT)       sh_dout = sh_din << sh_shamt;
        else if (sh_al == AL_ARITH) sh_dout = sd >>> sh_shamt;
        else                        sh_dout = sh_din >> sh_shamt;
    end

    int ncmp = 0, nerr = 0;
    int stp[8];
    int nstp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // whole-operation reference, independent of pass splitting
    function automatic int ref_res(int din, int amt, bit lr, bit al, bit rot);
        int v, k;
        if (rot) begin
            k = amt % 8;
            if (lr) v = (din << k) | (din >> (8 - k));
            else    v = (din >> k) | (din << (8 - k));
        end else if (lr)                 v = din << amt;
        else if (al && din[7])           v = (din | 32'hFFFF_FF00) >>> amt;
        else                             v = din >> amt;
        return v & 255;
    endfunction

    function automatic int ref_passes(int amt, bit rot);
        if (rot) return (amt % 8 == 0) ? 1 : 2;
        return (amt == 0) ? 1 : (amt + 6) / 7;
    endfunction

    task automatic drive(input bit rid, input logic [7:0] din, input logic [3:0] amt,
                         input bit lr, input bit al, input bit rot);
        if (rid) begin
            req1_din = din; req1_amt = amt; req1_lr = lr; req1_al = al; req1_rot = rot;
        end else begin
            req0_din = din; req0_amt = amt; req0_lr = lr; req0_al = al; req0_rot = rot;
        end
    endtask

    task automatic do_req(input bit rid, input logic [7:0] din, input logic [3:0] amt,
                          input bit lr, input bit al, input bit rot,
                          output logic [7:0] rdata, output logic rrid, output int lat);
        bit ok = 0;
        drive(rid, din, amt, lr, al, rot);
        req_valid[rid] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[rid]) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1 req_valid[rid] = 1'b0;
        lat = 0; nstp = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin lat = i; break; end
            if (nstp < 8) begin stp[nstp] = int'(sh_shamt); nstp++; end
        end
        if (lat == 0) chk("resp_timeout", 0, 1);
        rdata = resp_data; rrid = resp_id;
        @(posedge clk); #1;
    endtask

    task automatic check_req(input bit rid, input logic [7:0] din, input logic [3:0] amt,
                             input bit lr, input bit al, input bit rot,
                             input logic [7:0] exp_data, input int p, input string tag);
        logic [7:0] d; logic i; int lat, rem, st;
        do_req(rid, din, amt, lr, al, rot, d, i, lat);
        chk({tag, "_data"}, d, exp_data);
        chk({tag, "_id"}, i, rid);
        chk({tag, "_lat"}, lat, p + 1);
        chk({tag, "_passes"}, nstp, p);
        rem = amt;
        for (int j = 0; j < p && j < nstp; j++) begin
            if (rot) st = (j == 0) ? amt % 8 : 8 - amt % 8;
            else begin st = (rem > 7) ? 7 : rem; rem -= st; end
            chk({tag, "_step"}, stp[j], st);
        end
    endtask

    typedef struct {
        bit rid; logic [7:0] din; logic [3:0] amt; bit lr; bit al;
        logic [7:0] exp; int p;
    } vec_t;
    vec_t vt[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d; logic i; int lat, ng, nr, rid, amt, lr, al, din, rot;
        int gs[4], rs[4], rd[4], gc[4];
        bit seen;

        vt[0] = '{0, 8'h81,  1, 1, 0, 8'h02, 1};
        vt[1] = '{1, 8'h80, 10, 0, 1, 8'hFF, 2};
        vt[2] = '{0, 8'hFF, 15, 0, 0, 8'h00, 3};
        vt[3] = '{0, 8'hFF,  0, 0, 0, 8'hFF, 1};
        vt[4] = '{1, 8'h5A,  8, 1, 0, 8'h00, 2};
        vt[5] = '{0, 8'hB3,  9, 0, 1, 8'hFF, 2};
        vt[6] = '{1, 8'h73, 12, 0, 1, 8'h00, 2};
        vt[7] = '{0, 8'hC5,  7, 1, 1, 8'h80, 1};
        vt[8] = '{1, 8'h96, 14, 0, 0, 8'h00, 2};

        rst = 1; req_valid = 0; resp_ready = 1;
        drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_sh_shamt", sh_shamt, 0);
        chk("rst_sh_lr", sh_lr, 0);
        chk("rst_sh_al", sh_al, 0);
        @(posedge clk); #1 rst = 0;

        // reset in the 2nd SHIFT cycle of a 3-pass request
        drive(0, 8'hFF, 15, 0, 0, 0);
        req_valid[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[0]) begin seen = 1; break; end
        end
        chk("rstmid_accept", seen, 1);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("rstmid_resp_valid", resp_valid, 0);
        chk("rstmid_sh_shamt", sh_shamt, 0);
        chk("rstmid_acc", sh_din, 0);
        rst = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("rstmid_no_resp", seen, 0);
        @(posedge clk); #1;

        // round robin with both held; first tie after reset goes to requester 0
        drive(0, 8'h0F, 2, 1, 0, 0);
        drive(1, 8'hF0, 3, 0, 1, 0);
        req_valid = 2'b11;
        ng = 0; nr = 0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            @(negedge clk);
            if (req_valid != 0 && req_ready != 0 && ng < 4) begin
                gs[ng] = int'(req_ready[1]); gc[ng] = c; ng++;
            end
            if (resp_valid && nr < 4) begin rs[nr] = int'(resp_id); rd[nr] = int'(resp_data); nr++; end
            if (ng == 4 && req_valid != 0) begin @(posedge clk); #1 req_valid = 0; end
        end
        chk("rr_grants", ng, 4);
        chk("rr_resps", nr, 4);
        for (int k = 0; k < 4 && k < ng && k < nr; k++) begin
            chk("rr_grant", gs[k], k % 2);
            chk("rr_resp_id", rs[k], k % 2);
            chk("rr_resp_data", rd[k], (k % 2) ? 8'hFE : 8'h3C);
            if (k > 0) chk("rr_spacing", gc[k] - gc[k-1], 3);
        end
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++)
            check_req(vt[k].rid, vt[k].din, vt[k].amt, vt[k].lr, vt[k].al, 0,
                      vt[k].exp, vt[k].p, $sformatf("vec%0d", k));

        // stall: consumer holds off 5 cycles while requester 1 waits
        drive(0, 8'h81, 1, 1, 0, 0);
        req_valid[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[0]) begin seen = 1; break; end
        end
        chk("stall_accept", seen, 1);
        @(posedge clk); #1 req_valid[0] = 0; resp_ready = 0;
        drive(1, 8'h40, 3, 1, 0, 0);
        req_valid[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; break; end
        end
        chk("stall_resp", seen, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", resp_valid, 1);
            chk("stall_data", resp_data, 8'h02);
            chk("stall_id", resp_id, 0);
            chk("stall_ready", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1;
        check_req(1, 8'h40, 3, 1, 0, 0, 8'h00, 1, "held");

        for (int n = 0; n < 40; n++) begin
            rid = $urandom % 2; din = $urandom % 256; amt = $urandom % 16;
            lr = $urandom % 2; al = $urandom % 2;
`ifdef SHIFT_SCHED_ROT_EN
            rot = $urandom % 2;
`else
            rot = 0;
`endif
            check_req(rid[0], din[7:0], amt[3:0], lr[0], al[0], rot[0],
                      ref_res(din, amt, lr[0], al[0], rot[0]), ref_passes(amt, rot[0]), "rand");
        end

`ifdef SHIFT_SCHED_ROT_EN
        check_req(0, 8'h81, 1, 1, 0, 1, 8'h03, 2, "rot_l1");
        check_req(1, 8'h81, 8, 0, 0, 1, 8'h81, 1, "rot_k0");
        check_req(0, 8'h96, 3, 0, 1, 1, 8'hD2, 2, "rot_r3");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Controller that shares one external 8-bit barrel shifter between two requesters.
- Shift amounts of 0..15 are built up from repeated shifter passes of at most 7 bits each.
- A 2-way round-robin arbiter picks the requester, a small FSM sequences the passes, and one response channel returns the result tagged with the requester ID.
- Sits between the ALU/keyboard datapath clients and the shared shifter instance.

Parameters:
- DW, 8, data width; must match the shared shifter.
- SW, 3, shifter shamt width; one pass shifts at most 2^SW-1 = 7 bits.
- AW, 4, request amount width; amounts 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; at most one bit high, and only in IDLE.
- req0_din / req1_din  in  DW  operand.
- req0_amt / req1_amt  in  AW  total shift amount.
- req0_lr / req1_lr  in  1  direction: 1 = left, 0 = right.
- req0_al / req1_al  in  1  fill: 1 = arithmetic (right shifts fill with din[7]), 0 = logical (zero fill).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  DW  shifted result.
- resp_id  out  1  index of the requester that owns resp_data.
- sh_din  out  DW  drive to the shared shifter din.
- sh_shamt  out  SW  drive to the shared shifter shamt.
- sh_lr  out  1  drive to the shared shifter LR.
- sh_al  out  1  drive to the shared shifter AL.
- sh_dout  in  DW  combinational result from the shared shifter.

Behaviour:
- States: IDLE, SHIFT, RESP.
- Reset values: state = IDLE, acc = 0, rem = 0, resp_valid = 0, resp_data = 0, resp_id = 0, req_ready = 0, sh_shamt = 0, sh_lr = 0, sh_al = 0, last_grant = 1 (requester 0 wins the first tie).

IDLE:
- req_ready[g] = 1 combinationally for the granted requester g.
  - If only one req_valid bit is high, that requester is granted.
  - If both are high, g = ~last_grant.
- A handshake (valid & ready) latches acc = din, rem = amt, lr, al, id = g and last_grant = g, then moves to SHIFT.

SHIFT:
- Every SHIFT cycle drives sh_din = acc, sh_lr = lr, sh_al = al, and sh_shamt = step, where step = min(rem, 7).
- On the clock edge: acc <= sh_dout; rem <= rem - step.
- When rem - step == 0, go to RESP.
- amt = 0 still takes exactly one SHIFT cycle with step = 0 (pass-through).
- Number of passes P = max(1, ceil(amt/7)); P = 3 for amt = 15.

RESP:
- resp_valid = 1, resp_data = acc, resp_id = id.
- All three hold stable until resp_ready = 1 is sampled; then go to IDLE.
- resp_valid is registered and is never combinationally dependent on resp_ready.

Timing:
- Accept in cycle N → resp_valid first high in cycle N+P+1.
- Back-to-back throughput is one request per P+2 cycles when resp_ready is tied high.
- Outside SHIFT: sh_shamt = 0, sh_din = acc, sh_lr = lr, sh_al = al. This is a harmless pass-through of the shifter.

Boundary conditions:
- Left shifts always fill with zero; AL is ignored when lr = 1 (the shifter handles this).
- amt >= 8 logical → result 0x00.
- amt >= 8 arithmetic right → all bits equal to din[7].
- A requester dropping req_valid in a cycle where it is not granted has no effect.
- A request held during SHIFT/RESP waits; it is not lost.
- rst asserted in any state → IDLE on the next edge. The in-flight result is discarded with no response.

Optional Feature:
- Macro SHIFT_SCHED_ROT_EN adds per-requester input reqN_rot (1 bit).
- With the macro and rot = 1:
  - k = amt mod 8; al is ignored.
  - Pass A shifts logically by k in direction lr, and the FSM stores tmp = sh_dout.
  - Pass B shifts din logically by 8-k in the opposite direction.
  - Result = tmp | sh_dout; P = 2.
  - k = 0 → one pass-through cycle, result = din.
- Without the macro, the ports are absent and behaviour is exactly as above.

Decomposition:
- Package shift_sched_pkg holds:
  - State enum {IDLE, SHIFT, RESP}.
  - SH_MAX_STEP = 7.
  - LR_LEFT = 1'b1 and AL_ARITH = 1'b1.
  - The request struct: din, amt, lr, al, and rot when the macro is defined.
- One natural sub-module, shift_sched_rr_arb: 2-way round-robin arbiter.
  - Inputs: valid[1:0], last_grant, enable.
  - Outputs: one-hot grant[1:0] and grant index.

Test Plan:
- Req0: din = 0x81, amt = 1, lr = 1, al = 0; accepted cycle N → resp_data = 0x02, resp_id = 0, resp_valid at N+2.
- Req1: din = 0x80, amt = 10, lr = 0, al = 1 → two passes (7, 3), sh_shamt 7 then 3, resp_data = 0xFF at N+3.
- Req0: din = 0xFF, amt = 15, lr = 0, al = 0 → three passes (7, 7, 1), resp_data = 0x00 at N+4. Also amt = 0 → 0xFF at N+2.
- Both req_valid held high with 4 requests queued, resp_ready = 1 → grants go 0,1,0,1 and resp_id matches each grant.
- resp_ready low for 5 cycles after resp_valid → resp_data/resp_id stable, req_ready = 00 throughout, no new accept.
- rst pulsed during the 2nd SHIFT cycle → next cycle IDLE, resp_valid = 0, no response. With SHIFT_SCHED_ROT_EN: din = 0x81, amt = 1, lr = 1, rot = 1 → 0x03.
